// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: load-use stall, redirect select (JR > J > taken branch),
// halt/resume handling and saturating stall/flush event counters.
module fetch_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_ex,
    input  logic [4:0]       Rt_ex,
    input  logic [4:0]       Rs_id,
    input  logic [4:0]       Rt_id,
    input  logic             UseRt_id,
    input  logic             Branch_id,
    input  logic             Zero_id,
    input  logic             J_id,
    input  logic             JR_id,
    input  logic             Halt_id,
    input  logic             Resume,
    input  logic             clr_cnt,
    output logic             PC_IFWrite,
    output logic             IF_IDWrite,
    output logic             IF_flush,
    output logic             ID_EX_bubble,
    output logic             Z,
    output logic             J,
    output logic             JR,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        HALT   = 2'd2,
        RESUME = 2'd3
    } state_t;

    localparam logic [1:0] STALL_LOAD = 2'(STALL_CYCLES - 1);

    state_t           state_r;
    logic [1:0]       down_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             lu_s;
    logic             redir_s;
    logic             stall_inc_s;
    logic             flush_inc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Register 0 never carries a real dependency, so it cannot cause a hazard.
    assign lu_s    = MemRead_ex && (Rt_ex != 5'd0) &&
                     ((Rt_ex == Rs_id) || (UseRt_id && (Rt_ex == Rt_id)));
    assign redir_s = JR_id || J_id || (Branch_id && Zero_id);

    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;

    // Output and event decode from current state and ID/EX inputs.
    always_comb begin
        PC_IFWrite   = 1'b0;
        IF_IDWrite   = 1'b0;
        IF_flush     = 1'b0;
        ID_EX_bubble = 1'b0;
        Z            = 1'b0;
        J            = 1'b0;
        JR           = 1'b0;
        halted       = 1'b0;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        if (!reset) begin
            PC_IFWrite = 1'b0;
        end else begin
            case (state_r)
                RUN, RESUME: begin
                    if (lu_s) begin
                        ID_EX_bubble = 1'b1;
                        stall_inc_s  = 1'b1;
                    end else if (redir_s) begin
                        PC_IFWrite  = 1'b1;
                        IF_IDWrite  = 1'b1;
                        IF_flush    = 1'b1;
                        flush_inc_s = 1'b1;
                        if (JR_id) begin
                            JR = 1'b1;
                        end else if (J_id) begin
                            J = 1'b1;
                        end else begin
                            Z = 1'b1;
                        end
                    end else if ((state_r == RUN) && Halt_id) begin
                        ID_EX_bubble = 1'b1;
                    end else begin
                        PC_IFWrite = 1'b1;
                        IF_IDWrite = 1'b1;
                    end
                end
                STALL: begin
                    ID_EX_bubble = 1'b1;
                    stall_inc_s  = 1'b1;
                end
                HALT: begin
                    ID_EX_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: begin
                    PC_IFWrite = 1'b0;
                end
            endcase
        end
    end

    // State sequencing, stall down-counter and event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= RUN;
            down_r      <= 2'd0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RUN, RESUME: begin
                    if (lu_s) begin
                        if (STALL_CYCLES > 1) begin
                            down_r  <= STALL_LOAD;
                            state_r <= STALL;
                        end else begin
                            state_r <= RUN;
                        end
                    end else if (redir_s) begin
                        state_r <= RUN;
                    end else if ((state_r == RUN) && Halt_id) begin
                        state_r <= HALT;
                    end else begin
                        state_r <= RUN;
                    end
                end
                STALL: begin
                    down_r <= down_r - 2'd1;
                    if (down_r <= 2'd1) begin
                        state_r <= RUN;
                    end else begin
                        state_r <= STALL;
                    end
                end
                HALT: begin
                    if (Resume) begin
                        state_r <= RESUME;
                    end else begin
                        state_r <= HALT;
                    end
                end
                default: begin
                    state_r <= RUN;
                end
            endcase
            // Clear takes precedence over a same-cycle event.
            if (clr_cnt) begin
                stall_cnt_r <= {CNT_W{1'b0}};
                flush_cnt_r <= {CNT_W{1'b0}};
            end else begin
                if (stall_inc_s) begin
                    stall_cnt_r <= sat_inc(stall_cnt_r);
                end
                if (flush_inc_s) begin
                    flush_cnt_r <= sat_inc(flush_cnt_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: three instances (1/16, 3/16, 1/4 stall cycles/counter
// width) share one stimulus stream and are checked against a behavioural model.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, MemRead_ex, UseRt_id, Branch_id, Zero_id, J_id, JR_id;
    logic       Halt_id, Resume, clr_cnt;
    logic [4:0] Rt_ex, Rs_id, Rt_id;

    logic [2:0]  pcw, ifw, fl, bub, zs, js, jrs, hlt;
    logic [15:0] sc0, fc0, sc1, fc1;
    logic [3:0]  sc2, fc2;

    int compared = 0;
    int mism     = 0;

    // Model state per instance: mode 0=run 1=stall 2=halt 3=resume
    int m_mode[3];
    int m_left[3];
    int m_s[3];
    int m_f[3];
    int scy[3]  = '{1, 3, 1};
    int cmax[3] = '{65535, 65535, 15};

    fetch_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .MemRead_ex(MemRead_ex), .Rt_ex(Rt_ex), .Rs_id(Rs_id),
        .Rt_id(Rt_id), .UseRt_id(UseRt_id), .Branch_id(Branch_id), .Zero_id(Zero_id),
        .J_id(J_id), .JR_id(JR_id), .Halt_id(Halt_id), .Resume(Resume), .clr_cnt(clr_cnt),
        .PC_IFWrite(pcw[0]), .IF_IDWrite(ifw[0]), .IF_flush(fl[0]), .ID_EX_bubble(bub[0]),
        .Z(zs[0]), .J(js[0]), .JR(jrs[0]), .halted(hlt[0]), .stall_cnt(sc0), .flush_cnt(fc0));

    fetch_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .MemRead_ex(MemRead_ex), .Rt_ex(Rt_ex), .Rs_id(Rs_id),
        .Rt_id(Rt_id), .UseRt_id(UseRt_id), .Branch_id(Branch_id), .Zero_id(Zero_id),
        .J_id(J_id), .JR_id(JR_id), .Halt_id(Halt_id), .Resume(Resume), .clr_cnt(clr_cnt),
        .PC_IFWrite(pcw[1]), .IF_IDWrite(ifw[1]), .IF_flush(fl[1]), .ID_EX_bubble(bub[1]),
        .Z(zs[1]), .J(js[1]), .JR(jrs[1]), .halted(hlt[1]), .stall_cnt(sc1), .flush_cnt(fc1));

    fetch_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .MemRead_ex(MemRead_ex), .Rt_ex(Rt_ex), .Rs_id(Rs_id),
        .Rt_id(Rt_id), .UseRt_id(UseRt_id), .Branch_id(Branch_id), .Zero_id(Zero_id),
        .J_id(J_id), .JR_id(JR_id), .Halt_id(Halt_id), .Resume(Resume), .clr_cnt(clr_cnt),
        .PC_IFWrite(pcw[2]), .IF_IDWrite(ifw[2]), .IF_flush(fl[2]), .ID_EX_bubble(bub[2]),
        .Z(zs[2]), .J(js[2]), .JR(jrs[2]), .halted(hlt[2]), .stall_cnt(sc2), .flush_cnt(fc2));

    // Expected {PC_IFWrite, IF_IDWrite, IF_flush, bubble, Z, J, JR, halted}
    function automatic logic [7:0] exp_out(int i);
        bit lu;
        int win;
        lu  = MemRead_ex && Rt_ex != 5'd0 && (Rt_ex == Rs_id || (UseRt_id && Rt_ex == Rt_id));
        win = JR_id ? 3 : (J_id ? 2 : ((Branch_id && Zero_id) ? 1 : 0));
        if (!reset) return 8'h00;
        if (m_mode[i] == 1) return 8'b0001_0000;
        if (m_mode[i] == 2) return 8'b0001_0001;
        if (lu) return 8'b0001_0000;
        if (win == 3) return 8'b1110_0010;
        if (win == 2) return 8'b1110_0100;
        if (win == 1) return 8'b1110_1000;
        if (m_mode[i] == 0 && Halt_id) return 8'b0001_0000;
        return 8'b1100_0000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_left[i] = 0; m_s[i] = 0; m_f[i] = 0;
        end
    endtask

    task automatic model_clock();
        bit lu, win;
        lu  = MemRead_ex && Rt_ex != 5'd0 && (Rt_ex == Rs_id || (UseRt_id && Rt_ex == Rt_id));
        win = JR_id || J_id || (Branch_id && Zero_id);
        for (int i = 0; i < 3; i++) begin
            int ds, df;
            ds = 0; df = 0;
            if (m_mode[i] == 1) begin
                ds = 1;
                m_left[i]--;
                if (m_left[i] == 0) m_mode[i] = 0;
            end else if (m_mode[i] == 2) begin
                if (Resume) m_mode[i] = 3;
            end else if (lu) begin
                ds = 1;
                m_left[i] = scy[i] - 1;
                m_mode[i] = (m_left[i] > 0) ? 1 : 0;
            end else if (win) begin
                df = 1;
                m_mode[i] = 0;
            end else if (m_mode[i] == 0 && Halt_id) begin
                m_mode[i] = 2;
            end else begin
                m_mode[i] = 0;
            end
            if (clr_cnt) begin
                m_s[i] = 0; m_f[i] = 0;
            end else begin
                if (ds == 1 && m_s[i] < cmax[i]) m_s[i]++;
                if (df == 1 && m_f[i] < cmax[i]) m_f[i]++;
            end
        end
    endtask

    task automatic chk(string tag, int i, logic [63:0] obs, logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mism++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h", tag, i, obs, expv);
        end
    endtask

    task automatic check_now();
        logic [63:0] s, f;
        if (!reset) model_reset();
        for (int i = 0; i < 3; i++) begin
            s = (i == 0) ? {48'd0, sc0} : ((i == 1) ? {48'd0, sc1} : {60'd0, sc2});
            f = (i == 0) ? {48'd0, fc0} : ((i == 1) ? {48'd0, fc1} : {60'd0, fc2});
            chk("ctl", i, {56'd0, pcw[i], ifw[i], fl[i], bub[i], zs[i], js[i], jrs[i], hlt[i]},
                {56'd0, exp_out(i)});
            chk("stall_cnt", i, s, 64'(m_s[i]));
            chk("flush_cnt", i, f, 64'(m_f[i]));
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        check_now();
        if (reset) model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemRead_ex = 1'b0; Rt_ex = 5'd0; Rs_id = 5'd0; Rt_id = 5'd0; UseRt_id = 1'b0;
        Branch_id = 1'b0; Zero_id = 1'b0; J_id = 1'b0; JR_id = 1'b0; Halt_id = 1'b0;
        Resume = 1'b0; clr_cnt = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        model_reset();
        step(); step();
        reset = 1'b1;
        step();
        // load-use on rs
        MemRead_ex = 1'b1; Rt_ex = 5'd2; Rs_id = 5'd2;
        step();
        idle();
        step(); step(); step();
        // redirect priority, then untaken branch
        JR_id = 1'b1; J_id = 1'b1; Branch_id = 1'b1; Zero_id = 1'b1;
        step();
        idle(); Branch_id = 1'b1;
        step();
        idle();
        step();
        // halt, hold, resume with halt still in ID
        Halt_id = 1'b1;
        step();
        repeat (5) step();
        Resume = 1'b1;
        step();
        Resume = 1'b0;
        step();
        Halt_id = 1'b0;
        step();
        // load-use on rt together with a jump
        MemRead_ex = 1'b1; Rt_ex = 5'd5; Rt_id = 5'd5; UseRt_id = 1'b1; J_id = 1'b1;
        step();
        MemRead_ex = 1'b0;
        step(); step();
        idle();
        step();
        // saturate the narrow counter, then clear on a stall cycle
        MemRead_ex = 1'b1; Rt_ex = 5'd7; Rs_id = 5'd7;
        repeat (20) step();
        clr_cnt = 1'b1;
        step();
        idle();
        step(); step(); step();
        // reset asserted while halted
        Halt_id = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        check_now();
        step();
        reset = 1'b1;
        Halt_id = 1'b0;
        step();
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            MemRead_ex = ($urandom_range(0, 2) == 0);
            Rt_ex      = 5'($urandom_range(0, 3));
            Rs_id      = 5'($urandom_range(0, 3));
            Rt_id      = 5'($urandom_range(0, 3));
            UseRt_id   = 1'($urandom_range(0, 1));
            Branch_id  = ($urandom_range(0, 3) == 0);
            Zero_id    = 1'($urandom_range(0, 1));
            J_id       = ($urandom_range(0, 7) == 0);
            JR_id      = ($urandom_range(0, 7) == 0);
            Halt_id    = ($urandom_range(0, 7) == 0);
            Resume     = ($urandom_range(0, 5) == 0);
            clr_cnt    = ($urandom_range(0, 39) == 0);
            reset      = ($urandom_range(0, 99) != 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
